// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution tile scheduler.
package conv_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COMP  = 3'd2,
        ST_GAP   = 3'd3,
        ST_STORE = 3'd4,
        ST_NEXT  = 3'd5
    } sched_state_e;

    // Default layer geometry
    localparam int DEF_N         = 32;
    localparam int DEF_M         = 32;
    localparam int DEF_R         = 64;
    localparam int DEF_C         = 16;
    localparam int DEF_TN        = 16;
    localparam int DEF_TM        = 16;
    localparam int DEF_TR        = 64;
    localparam int DEF_TC        = 16;
    localparam int DEF_K         = 3;
    localparam int DEF_AW        = 32;
    localparam int DEF_STORE_GAP = 100;

    // Number of tiles along one dimension
    function automatic int tiles_per_dim(input int total, input int tile);
        return total / tile;
    endfunction

    // Total tile count for a layer
    function automatic int total_tiles(input int n, input int tn, input int m, input int tm,
                                       input int r, input int tr, input int c, input int tc);
        return tiles_per_dim(n, tn) * tiles_per_dim(r, tr) * tiles_per_dim(c, tc) * tiles_per_dim(m, tm);
    endfunction

    // Weights per kernel plane
    function automatic int kernel_area(input int k);
        return k * k;
    endfunction

    // Width of the gap counter; at least one bit so the register always exists
    function automatic int gap_cnt_width(input int gap);
        return (gap < 2) ? 1 : $clog2(gap + 1);
    endfunction

    localparam int DEF_N_TILES = tiles_per_dim(DEF_N, DEF_TN);
    localparam int DEF_M_TILES = tiles_per_dim(DEF_M, DEF_TM);
    localparam int DEF_R_TILES = tiles_per_dim(DEF_R, DEF_TR);
    localparam int DEF_C_TILES = tiles_per_dim(DEF_C, DEF_TC);
    localparam int DEF_T       = total_tiles(DEF_N, DEF_TN, DEF_M, DEF_TM, DEF_R, DEF_TR, DEF_C, DEF_TC);
    localparam int DEF_KK      = kernel_area(DEF_K);
    localparam int DEF_GAP_W   = gap_cnt_width(DEF_STORE_GAP);

endpackage

// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between the tile scheduler and the host / load-compute-store engines.
interface conv_tile_sched_if import conv_sched_pkg::*; #(parameter int AW = DEF_AW) ();

    logic          conv_start;
    logic          in_fm_load_done;
    logic          weight_load_done;
    logic          out_fm_load_done;
    logic          conv_computing_done;
    logic          conv_tile_store_done;
    logic          in_fm_load_start;
    logic          weight_load_start;
    logic          out_fm_load_start;
    logic          conv_computing_start;
    logic          conv_tile_store_start;
    logic [AW-1:0] in_fm_base;
    logic [AW-1:0] weight_base;
    logic [AW-1:0] out_fm_base;
    logic [AW-1:0] tile_cnt;
    logic          busy;
    logic          conv_done;

    // Scheduler side
    modport master (
        input  conv_start, in_fm_load_done, weight_load_done, out_fm_load_done,
               conv_computing_done, conv_tile_store_done,
        output in_fm_load_start, weight_load_start, out_fm_load_start,
               conv_computing_start, conv_tile_store_start,
               in_fm_base, weight_base, out_fm_base, tile_cnt, busy, conv_done
    );

    // Host / engine side
    modport slave (
        output conv_start, in_fm_load_done, weight_load_done, out_fm_load_done,
               conv_computing_done, conv_tile_store_done,
        input  in_fm_load_start, weight_load_start, out_fm_load_start,
               conv_computing_start, conv_tile_store_start,
               in_fm_base, weight_base, out_fm_base, tile_cnt, busy, conv_done
    );

endinterface

// File: rtl/conv_tile_iter.sv
// Nested n0/r0/c0/m0 tile counters (m0 innermost) with registered base addresses.
// Bases are computed from the next-index values so they change on the same edge as the indices.
module conv_tile_iter import conv_sched_pkg::*; #(
    parameter int N  = DEF_N,
    parameter int M  = DEF_M,
    parameter int R  = DEF_R,
    parameter int C  = DEF_C,
    parameter int Tn = DEF_TN,
    parameter int Tm = DEF_TM,
    parameter int Tr = DEF_TR,
    parameter int Tc = DEF_TC,
    parameter int K  = DEF_K,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          clear,
    output logic          last,
    output logic [AW-1:0] in_fm_base,
    output logic [AW-1:0] weight_base,
    output logic [AW-1:0] out_fm_base,
    output logic [AW-1:0] tile_cnt
);

    localparam logic [AW-1:0] M_L    = AW'(M);
    localparam logic [AW-1:0] R_L    = AW'(R);
    localparam logic [AW-1:0] C_L    = AW'(C);
    localparam logic [AW-1:0] KK_L   = AW'(kernel_area(K));
    localparam logic [AW-1:0] TN_L   = AW'(Tn);
    localparam logic [AW-1:0] TM_L   = AW'(Tm);
    localparam logic [AW-1:0] TR_L   = AW'(Tr);
    localparam logic [AW-1:0] TC_L   = AW'(Tc);
    localparam logic [AW-1:0] N_LAST = AW'(N - Tn);
    localparam logic [AW-1:0] M_LAST = AW'(M - Tm);
    localparam logic [AW-1:0] R_LAST = AW'(R - Tr);
    localparam logic [AW-1:0] C_LAST = AW'(C - Tc);

    logic [AW-1:0] n0_r, r0_r, c0_r, m0_r, tile_r;
    logic [AW-1:0] n0_s, r0_s, c0_s, m0_s, tile_s;
    logic [AW-1:0] in_fm_base_r, weight_base_r, out_fm_base_r;
    logic          m_wrap_s, c_wrap_s, r_wrap_s, n_wrap_s;

    // Next-index selection: innermost-first wrap with carry
    always_comb begin
        n0_s     = n0_r;
        r0_s     = r0_r;
        c0_s     = c0_r;
        m0_s     = m0_r;
        tile_s   = tile_r;
        m_wrap_s = (m0_r == M_LAST);
        c_wrap_s = (c0_r == C_LAST);
        r_wrap_s = (r0_r == R_LAST);
        n_wrap_s = (n0_r == N_LAST);
        if (clear) begin
            n0_s   = '0;
            r0_s   = '0;
            c0_s   = '0;
            m0_s   = '0;
            tile_s = '0;
        end else if (advance) begin
            tile_s = tile_r + AW'(1);
            if (m_wrap_s) begin
                m0_s = '0;
                if (c_wrap_s) begin
                    c0_s = '0;
                    if (r_wrap_s) begin
                        r0_s = '0;
                        n0_s = n_wrap_s ? '0 : (n0_r + TN_L);
                    end else begin
                        r0_s = r0_r + TR_L;
                    end
                end else begin
                    c0_s = c0_r + TC_L;
                end
            end else begin
                m0_s = m0_r + TM_L;
            end
        end else begin
            tile_s = tile_r;
        end
    end

    // Index and base-address registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            n0_r          <= '0;
            r0_r          <= '0;
            c0_r          <= '0;
            m0_r          <= '0;
            tile_r        <= '0;
            in_fm_base_r  <= '0;
            weight_base_r <= '0;
            out_fm_base_r <= '0;
        end else begin
            n0_r          <= n0_s;
            r0_r          <= r0_s;
            c0_r          <= c0_s;
            m0_r          <= m0_s;
            tile_r        <= tile_s;
            in_fm_base_r  <= (m0_s * R_L + r0_s) * C_L + c0_s;
            weight_base_r <= (n0_s * M_L + m0_s) * KK_L;
            out_fm_base_r <= (n0_s * R_L + r0_s) * C_L + c0_s;
        end
    end

    assign last        = (n0_r == N_LAST) && (r0_r == R_LAST) && (c0_r == C_LAST) && (m0_r == M_LAST);
    assign in_fm_base  = in_fm_base_r;
    assign weight_base = weight_base_r;
    assign out_fm_base = out_fm_base_r;
    assign tile_cnt    = tile_r;

endmodule

// File: rtl/conv_tile_sched.sv
// Layer-level tile scheduler: sequences load, compute, gap and store for every tile.
module conv_tile_sched import conv_sched_pkg::*; #(
    parameter int N         = DEF_N,
    parameter int M         = DEF_M,
    parameter int R         = DEF_R,
    parameter int C         = DEF_C,
    parameter int Tn        = DEF_TN,
    parameter int Tm        = DEF_TM,
    parameter int Tr        = DEF_TR,
    parameter int Tc        = DEF_TC,
    parameter int K         = DEF_K,
    parameter int AW        = DEF_AW,
    parameter int STORE_GAP = DEF_STORE_GAP
) (
    input logic               clk,
    input logic               rst,
    conv_tile_sched_if.master bus
);

    localparam int            GW         = gap_cnt_width(STORE_GAP);
    localparam bit            GAP_BYPASS = (STORE_GAP == 0);
    // The GAP state itself accounts for one of the idle cycles
    localparam logic [GW-1:0] GAP_LOAD   = (STORE_GAP > 0) ? GW'(STORE_GAP - 1) : '0;

    sched_state_e  st_r, st_s;
    logic          in_stk_r, w_stk_r, out_stk_r;
    logic          in_stk_s, w_stk_s, out_stk_s;
    logic [GW-1:0] gap_r, gap_s;
    logic          all_loaded_s;
    logic          last_s, advance_s, clear_s;
    logic          ld_start_s, comp_start_s, store_start_s, done_s, busy_s;
    logic          ld_start_r, comp_start_r, store_start_r, done_r, busy_r;
    logic [AW-1:0] in_fm_base_s, weight_base_s, out_fm_base_s, tile_cnt_s;

    // Same-cycle done pulses count toward completion
    assign all_loaded_s = (in_stk_r  | bus.in_fm_load_done)  &
                          (w_stk_r   | bus.weight_load_done) &
                          (out_stk_r | bus.out_fm_load_done);

    conv_tile_iter #(
        .N(N), .M(M), .R(R), .C(C), .Tn(Tn), .Tm(Tm), .Tr(Tr), .Tc(Tc), .K(K), .AW(AW)
    ) u_iter (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance_s),
        .clear       (clear_s),
        .last        (last_s),
        .in_fm_base  (in_fm_base_s),
        .weight_base (weight_base_s),
        .out_fm_base (out_fm_base_s),
        .tile_cnt    (tile_cnt_s)
    );

    // Next-state logic
    always_comb begin
        st_s = st_r;
        case (st_r)
            ST_IDLE:  if (bus.conv_start) st_s = ST_LOAD; else st_s = ST_IDLE;
            ST_LOAD:  if (all_loaded_s) st_s = ST_COMP; else st_s = ST_LOAD;
            ST_COMP:  if (bus.conv_computing_done) st_s = GAP_BYPASS ? ST_STORE : ST_GAP;
                      else st_s = ST_COMP;
            ST_GAP:   if (gap_r == '0) st_s = ST_STORE; else st_s = ST_GAP;
            ST_STORE: if (bus.conv_tile_store_done) st_s = ST_NEXT; else st_s = ST_STORE;
            ST_NEXT:  if (last_s) st_s = ST_IDLE; else st_s = ST_LOAD;
            default:  st_s = ST_IDLE;
        endcase
    end

    // Output, sticky-bit and gap-counter next values
    always_comb begin
        ld_start_s    = ((st_r == ST_IDLE) && bus.conv_start) || ((st_r == ST_NEXT) && !last_s);
        comp_start_s  = (st_r == ST_LOAD) && all_loaded_s;
        store_start_s = ((st_r == ST_COMP) && bus.conv_computing_done && GAP_BYPASS) ||
                        ((st_r == ST_GAP) && (gap_r == '0));
        done_s        = (st_r == ST_NEXT) && last_s;
        busy_s        = (st_s != ST_IDLE);
        advance_s     = (st_r == ST_NEXT) && !last_s;
        clear_s       = done_s;
        if (ld_start_s) begin
            in_stk_s  = 1'b0;
            w_stk_s   = 1'b0;
            out_stk_s = 1'b0;
        end else if (st_r == ST_LOAD) begin
            in_stk_s  = in_stk_r  | bus.in_fm_load_done;
            w_stk_s   = w_stk_r   | bus.weight_load_done;
            out_stk_s = out_stk_r | bus.out_fm_load_done;
        end else begin
            in_stk_s  = in_stk_r;
            w_stk_s   = w_stk_r;
            out_stk_s = out_stk_r;
        end
        if ((st_r == ST_COMP) && bus.conv_computing_done) begin
            gap_s = GAP_LOAD;
        end else if ((st_r == ST_GAP) && (gap_r != '0)) begin
            gap_s = gap_r - GW'(1);
        end else begin
            gap_s = gap_r;
        end
    end

    // State, sticky bits, gap counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_r          <= ST_IDLE;
            in_stk_r      <= 1'b0;
            w_stk_r       <= 1'b0;
            out_stk_r     <= 1'b0;
            gap_r         <= '0;
            ld_start_r    <= 1'b0;
            comp_start_r  <= 1'b0;
            store_start_r <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            st_r          <= st_s;
            in_stk_r      <= in_stk_s;
            w_stk_r       <= w_stk_s;
            out_stk_r     <= out_stk_s;
            gap_r         <= gap_s;
            ld_start_r    <= ld_start_s;
            comp_start_r  <= comp_start_s;
            store_start_r <= store_start_s;
            done_r        <= done_s;
            busy_r        <= busy_s;
        end
    end

    assign bus.in_fm_load_start      = ld_start_r;
    assign bus.weight_load_start     = ld_start_r;
    assign bus.out_fm_load_start     = ld_start_r;
    assign bus.conv_computing_start  = comp_start_r;
    assign bus.conv_tile_store_start = store_start_r;
    assign bus.conv_done             = done_r;
    assign bus.busy                  = busy_r;
    assign bus.in_fm_base            = in_fm_base_s;
    assign bus.weight_base           = weight_base_s;
    assign bus.out_fm_base           = out_fm_base_s;
    assign bus.tile_cnt              = tile_cnt_s;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched: table-driven tile expectations fed through a scoreboard.
module tb_conv_tile_sched;

    typedef struct {
        logic [31:0] tile;
        logic [31:0] in_b;
        logic [31:0] w_b;
        logic [31:0] o_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_tile_sched_if #(.AW(32)) b0 ();
    conv_tile_sched_if #(.AW(32)) g0 ();

    conv_tile_sched #(.STORE_GAP(100)) dut    (.clk(clk), .rst(rst), .bus(b0));
    conv_tile_sched #(.STORE_GAP(0))   dut_g0 (.clk(clk), .rst(rst), .bus(g0));

    vec_t tbl [4];
    vec_t sb [$];
    vec_t cur;

    int total = 0;
    int bad   = 0;
    int n_ld, n_cp, n_st, n_done;
    int ld_cyc, cp_cyc, st_cyc, start_cyc;
    int t_ld, t_cp, t_st;
    int b2b_left;
    int t0;
    bit auto_en, start_req, m_in, m_w, m_out, m_cp, m_st, m_rst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_layer();
        for (int i = 0; i < 4; i++) sb.push_back(tbl[i]);
    endfunction

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_busy"},   64'(b0.busy), 64'd0);
        chk({tag, "_tile"},   64'(b0.tile_cnt), 64'd0);
        chk({tag, "_in_b"},   64'(b0.in_fm_base), 64'd0);
        chk({tag, "_w_b"},    64'(b0.weight_base), 64'd0);
        chk({tag, "_o_b"},    64'(b0.out_fm_base), 64'd0);
        chk({tag, "_pulses"}, 64'({b0.in_fm_load_start, b0.weight_load_start, b0.out_fm_load_start,
                                   b0.conv_computing_start, b0.conv_tile_store_start, b0.conv_done}), 64'd0);
    endtask

    // One cycle: drive inputs for this cycle, then observe the DUT outputs registered at the last edge
    task automatic tick();
        @(negedge clk);
        rst = m_rst ? 1'b0 : 1'b1;
        m_rst = 1'b0;
        b0.conv_start = start_req;
        if (start_req) start_cyc = cyc;
        start_req = 1'b0;
        b0.in_fm_load_done      = m_in;
        b0.weight_load_done     = m_w;
        b0.out_fm_load_done     = m_out;
        b0.conv_computing_done  = m_cp;
        b0.conv_tile_store_done = m_st;
        {m_in, m_w, m_out, m_cp, m_st} = 5'b0;
        if (auto_en) begin
            if (t_ld > 0) begin
                t_ld--;
                if (t_ld == 0) {b0.in_fm_load_done, b0.weight_load_done, b0.out_fm_load_done} = 3'b111;
            end
            if (t_cp > 0) begin
                t_cp--;
                if (t_cp == 0) b0.conv_computing_done = 1'b1;
            end
            if (t_st > 0) begin
                t_st--;
                if (t_st == 0) b0.conv_tile_store_done = 1'b1;
            end
        end
        if (b0.in_fm_load_start) begin
            n_ld++;
            ld_cyc = cyc;
            chk("load_starts_together", 64'({b0.weight_load_start, b0.out_fm_load_start}), 64'd3);
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("tile_cnt",    64'(b0.tile_cnt),    64'(cur.tile));
                chk("in_fm_base",  64'(b0.in_fm_base),  64'(cur.in_b));
                chk("weight_base", 64'(b0.weight_base), 64'(cur.w_b));
                chk("out_fm_base", 64'(b0.out_fm_base), 64'(cur.o_b));
            end
            if (auto_en) t_ld = 5;
        end
        if (b0.conv_computing_start) begin
            n_cp++;
            cp_cyc = cyc;
            if (auto_en) t_cp = 5;
        end
        if (b0.conv_tile_store_start) begin
            n_st++;
            st_cyc = cyc;
            chk("stable_tile_cnt", 64'(b0.tile_cnt),   64'(cur.tile));
            chk("stable_w_base",   64'(b0.weight_base), 64'(cur.w_b));
            if (auto_en) t_st = 5;
        end
        if (b0.conv_done) begin
            n_done++;
            if (b2b_left > 0) begin
                b2b_left--;
                push_layer();
                start_req = 1'b1;
            end
        end
    endtask

    task automatic clear_counts();
        n_ld = 0; n_cp = 0; n_st = 0; n_done = 0;
        t_ld = 0; t_cp = 0; t_st = 0;
    endtask

    initial begin
        tbl[0] = '{32'd0, 32'd0,     32'd0,    32'd0};
        tbl[1] = '{32'd1, 32'd16384, 32'd144,  32'd0};
        tbl[2] = '{32'd2, 32'd0,     32'd4608, 32'd16384};
        tbl[3] = '{32'd3, 32'd16384, 32'd4752, 32'd16384};

        rst = 1'b0;
        {b0.conv_start, b0.in_fm_load_done, b0.weight_load_done, b0.out_fm_load_done,
         b0.conv_computing_done, b0.conv_tile_store_done} = 6'b0;
        {g0.conv_start, g0.in_fm_load_done, g0.weight_load_done, g0.out_fm_load_done,
         g0.conv_computing_done, g0.conv_tile_store_done} = 6'b0;
        {auto_en, start_req, m_in, m_w, m_out, m_cp, m_st, m_rst} = 8'b0;
        b2b_left = 0;
        clear_counts();
        ld_cyc = 0; cp_cyc = 0; st_cyc = 0; start_cyc = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_rst_vals("reset");
        chk("reset_g0_busy", 64'(g0.busy), 64'd0);

        // Full layer with engines answering 5 cycles after each start
        tick();
        auto_en = 1'b1;
        push_layer();
        start_req = 1'b1;
        tick();
        tick();
        chk("start_latency", 64'(ld_cyc), 64'(start_cyc + 1));
        chk("busy_after_start", 64'(b0.busy), 64'd1);
        for (int i = 0; i < 2000 && n_done < 1; i++) tick();
        chk("layer1_done", 64'(n_done), 64'd1);
        chk("layer1_loads", 64'(n_ld), 64'd4);
        chk("layer1_comps", 64'(n_cp), 64'd4);
        chk("layer1_stores", 64'(n_st), 64'd4);
        chk("layer1_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        chk_rst_vals("after_layer");

        // Hand-driven corner cases: loader order, ignored events, gap timing, mid-gap reset
        auto_en = 1'b0;
        clear_counts();
        push_layer();
        start_req = 1'b1;
        tick();
        tick();
        chk("man_first_load", 64'(n_ld), 64'd1);
        m_out = 1'b1;
        tick();
        start_req = 1'b1;
        m_cp = 1'b1;
        tick();
        m_in = 1'b1;
        tick();
        tick();
        chk("no_early_comp", 64'(n_cp), 64'd0);
        m_w = 1'b1;
        tick();
        t0 = cyc;
        tick();
        chk("comp_after_last_done", 64'(cp_cyc), 64'(t0 + 1));
        chk("comp_once", 64'(n_cp), 64'd1);
        chk("ignored_start_no_load", 64'(n_ld), 64'd1);
        chk("busy_in_comp", 64'(b0.busy), 64'd1);
        m_cp = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 150 && n_st == 0; i++) tick();
        chk("gap100_store_time", 64'(st_cyc), 64'(t0 + 101));
        chk("gap100_store_once", 64'(n_st), 64'd1);
        m_st = 1'b1;
        tick();
        t0 = cyc;
        for (int i = 0; i < 10 && n_ld < 2; i++) tick();
        chk("next_load_time", 64'(ld_cyc), 64'(t0 + 2));
        m_in = 1'b1; m_w = 1'b1; m_out = 1'b1;
        tick();
        t0 = cyc;
        tick();
        chk("same_cycle_done_comp", 64'(cp_cyc), 64'(t0 + 1));
        chk("comp_count_2", 64'(n_cp), 64'd2);
        m_cp = 1'b1;
        tick();
        repeat (50) tick();
        chk("in_gap_no_store", 64'(n_st), 64'd1);
        m_rst = 1'b1;
        tick();
        tick();
        chk_rst_vals("mid_gap_reset");
        repeat (120) tick();
        chk("no_store_after_reset", 64'(n_st), 64'd1);
        chk("idle_after_reset", 64'(b0.busy), 64'd0);

        // Two back-to-back layers, restart from tile 0
        sb.delete();
        clear_counts();
        auto_en = 1'b1;
        push_layer();
        b2b_left = 1;
        start_req = 1'b1;
        for (int i = 0; i < 4000 && n_done < 2; i++) tick();
        chk("b2b_done", 64'(n_done), 64'd2);
        chk("b2b_loads", 64'(n_ld), 64'd8);
        chk("b2b_comps", 64'(n_cp), 64'd8);
        chk("b2b_stores", 64'(n_st), 64'd8);
        chk("b2b_sb_empty", 64'(sb.size()), 64'd0);
        auto_en = 1'b0;

        // Zero store gap on the second instance
        @(negedge clk);
        g0.conv_start = 1'b1;
        @(negedge clk);
        g0.conv_start = 1'b0;
        chk("g0_load_start", 64'(g0.in_fm_load_start), 64'd1);
        chk("g0_in_base0", 64'(g0.in_fm_base), 64'd0);
        {g0.in_fm_load_done, g0.weight_load_done, g0.out_fm_load_done} = 3'b111;
        @(negedge clk);
        {g0.in_fm_load_done, g0.weight_load_done, g0.out_fm_load_done} = 3'b000;
        chk("g0_comp_start", 64'(g0.conv_computing_start), 64'd1);
        g0.conv_computing_done = 1'b1;
        @(negedge clk);
        g0.conv_computing_done = 1'b0;
        chk("gap0_store_time", 64'(g0.conv_tile_store_start), 64'd1);
        g0.conv_tile_store_done = 1'b1;
        @(negedge clk);
        g0.conv_tile_store_done = 1'b0;
        chk("g0_next_quiet", 64'(g0.in_fm_load_start), 64'd0);
        @(negedge clk);
        chk("g0_tile1_load", 64'(g0.in_fm_load_start), 64'd1);
        chk("g0_tile1_cnt", 64'(g0.tile_cnt), 64'd1);
        chk("g0_tile1_in_base", 64'(g0.in_fm_base), 64'd16384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
